gcd_rr_scheduler: RTL and testbench
===================================

// Module: gcd_rr_scheduler
// PURPOSE
//  Round-robin scheduler that shares one GCD compute core among N_REQ requesters.
//  Each requester has a valid/ready request channel (operands A, B) and a valid/ready response channel.
//  Exactly one job is in flight at a time; the block sits between the requester masters and the core.
//  Short-circuits zero operands and returns an error if the core never answers (watchdog).
// PARAMETERS
//  N_REQ    4   number of requesters, >=2
//  DATA_W   4   operand/result width
//  TIMEOUT  64  max cycles in WAIT before error response, >=2
// PORTS
//  clk_i          in   1             clock; all logic on rising edge
//  rst_i          in   1             synchronous, active-high reset
//  req_valid_i    in   N_REQ         requester i has a job
//  req_ready_o    out  N_REQ         job accepted from requester i (one-hot or zero)
//  req_a_i        in   N_REQ*DATA_W  operand A, slice i = [i*DATA_W +: DATA_W]
//  req_b_i        in   N_REQ*DATA_W  operand B, same slicing
//  rsp_valid_o    out  N_REQ         response for requester i (one-hot or zero)
//  rsp_ready_i    in   N_REQ         requester i accepts response
//  rsp_data_o     out  DATA_W        GCD result, shared by all requesters
//  rsp_err_o      out  1             1 = timeout, rsp_data_o = 0
//  grant_id_o     out  $clog2(N_REQ) index of the current/last granted requester
//  core_req_o     out  1             one-cycle start pulse to the core
//  core_a_o       out  DATA_W        operand A to core, held stable from start to result
//  core_b_o       out  DATA_W        operand B to core, same hold rule
//  core_busy_i    in   1             core computing
//  core_valid_i   in   1             core result valid, one-cycle pulse
//  core_result_i  in   DATA_W        core result
// BEHAVIOUR
//  Reset:
//   - state = IDLE, rr_ptr = 0, grant_id_o = 0.
//   - All outputs are 0: req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, core_req_o, core_a_o, core_b_o.
//   - A reset during any state abandons the job; core_req_o is low the following cycle.
//  FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  IDLE:
//   - If core_busy_i == 0 and any req_valid_i is set, pick g = first set bit at or after rr_ptr, wrapping modulo N_REQ.
//   - req_ready_o[g] = 1 combinationally in that cycle; no other bit is set.
//   - On the handshake edge, register A, B and grant_id_o = g.
//   - If A == 0 or B == 0: go to RESP with rsp_data_o = A|B (gcd(0,x) = x, gcd(0,0) = 0), err = 0. The core is never started.
//   - Otherwise go to ISSUE.
//   - While core_busy_i == 1, req_ready_o stays all 0.
//  ISSUE:
//   - core_req_o = 1 for exactly one cycle.
//   - core_a_o and core_b_o carry the latched operands; they are held until leaving WAIT.
//   - Next state is WAIT; the timer clears to 0.
//  WAIT:
//   - The timer increments every cycle.
//   - On core_valid_i: capture core_result_i into rsp_data_o, err = 0, go to RESP.
//   - If the timer reaches TIMEOUT-1 without core_valid_i: rsp_data_o = 0, err = 1, go to RESP.
//   - If core_valid_i and timeout coincide, the valid result wins.
//  RESP:
//   - rsp_valid_o[grant_id_o] = 1; rsp_data_o and rsp_err_o are held stable until the handshake.
//   - On rsp_ready_i[grant_id_o]: rr_ptr = (grant_id_o+1) mod N_REQ, go to IDLE.
//   - rsp_ready_i bits of non-granted requesters are ignored.
//  Stray inputs: core_valid_i outside WAIT is ignored; core_busy_i is only sampled in IDLE.
//  Latency, handshake at cycle T:
//   - core_req_o is high in T+1.
//   - rsp_valid_o rises 1 cycle after core_valid_i.
//   - Zero-operand jobs: rsp_valid_o is high in T+1.
//   - Minimum gap between consecutive grants is 1 IDLE cycle after the response handshake.
//  Fairness: a requester holding req_valid_i waits at most N_REQ-1 other jobs.
// TESTING
//  1. Req0 A=12, B=8, core model returns 4 after 5 cycles
//     -> core_req_o pulses once in T+1; rsp_valid_o=0001, data=4, err=0.
//  2. All 4 req_valid_i high after reset
//     -> grants in order 0,1,2,3; then req0 and req3 high with rr_ptr=0 -> 0 is granted before 3.
//  3. Req2 A=0, B=9 -> core_req_o never asserted; rsp_valid_o=0100 in T+1, data=9.
//     Then A=0, B=0 -> data=0.
//  4. rsp_ready_i held low for 10 cycles in RESP
//     -> rsp_valid_o and data stable; req_ready_o stays 0 despite other valid requests.
//  5. Core model never pulses core_valid_i
//     -> exactly TIMEOUT cycles in WAIT, then rsp_err_o=1, data=0; the next job proceeds normally.
//  6. rst_i asserted mid-WAIT
//     -> next cycle all outputs 0, rr_ptr=0; a late core_valid_i is ignored; a new request is granted normally.

Source files
------------

// File: rtl/gcd_rr_scheduler_if.sv
// Purpose : bundles the requester-side and core-side signals of the shared GCD scheduler.
// Latency : none (wiring only).
// Backpressure: carries valid/ready on both requester channels; the core side is start/result pulses.
// Ports (members):
//   req_valid_i/req_ready_o/req_a_i/req_b_i      request channel, one lane per requester
//   rsp_valid_o/rsp_ready_i/rsp_data_o/rsp_err_o response channel, shared data/err
//   grant_id_o                                   current/last granted requester
//   core_req_o/core_a_o/core_b_o                 start pulse and operands to the core
//   core_busy_i/core_valid_i/core_result_i       core status and result
// Modports: slave = scheduler view, master = requesters + core view.
interface gcd_rr_scheduler_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        req_valid_i;
  logic [N_REQ-1:0]        req_ready_o;
  logic [N_REQ*DATA_W-1:0] req_a_i;
  logic [N_REQ*DATA_W-1:0] req_b_i;
  logic [N_REQ-1:0]        rsp_valid_o;
  logic [N_REQ-1:0]        rsp_ready_i;
  logic [DATA_W-1:0]       rsp_data_o;
  logic                    rsp_err_o;
  logic [ID_W-1:0]         grant_id_o;
  logic                    core_req_o;
  logic [DATA_W-1:0]       core_a_o;
  logic [DATA_W-1:0]       core_b_o;
  logic                    core_busy_i;
  logic                    core_valid_i;
  logic [DATA_W-1:0]       core_result_i;

  modport slave (
    input  req_valid_i, req_a_i, req_b_i, rsp_ready_i,
           core_busy_i, core_valid_i, core_result_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, grant_id_o,
           core_req_o, core_a_o, core_b_o
  );

  modport master (
    output req_valid_i, req_a_i, req_b_i, rsp_ready_i,
           core_busy_i, core_valid_i, core_result_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, grant_id_o,
           core_req_o, core_a_o, core_b_o
  );
endinterface

// File: rtl/gcd_rr_scheduler.sv
// Purpose : round-robin sharing of one GCD core among N_REQ requesters, one job in flight.
// Latency : core_req_o one cycle after accept; response one cycle after core result; zero operands answer next cycle.
// Backpressure: no request accepted until the response handshake completes; response held until rsp_ready_i.
// Ports:
//   clk_i  clock, rising edge
//   rst_i  synchronous active-high reset
//   bus    gcd_rr_scheduler_if.slave (request/response channels, core start/result)
module gcd_rr_scheduler #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  gcd_rr_scheduler_if.slave    bus
);

  localparam int ID_W = $clog2(N_REQ);
  localparam int TM_W = $clog2(TIMEOUT);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     r_grant_id;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_rsp_err;
  logic [TM_W-1:0]     r_timer;

  logic                w_any;
  logic [ID_W-1:0]     w_pick;
  logic [DATA_W-1:0]   w_a_sel;
  logic [DATA_W-1:0]   w_b_sel;
  logic                w_accept;
  logic                w_zero_op;
  logic                w_timeout;
  logic                w_rsp_hs;

  // Rotating priority: scan offsets from the highest down so the lowest
  // offset from r_rr_ptr with a pending request is the one left in w_pick.
  always_comb begin : arb
    int v_idx;
    w_any  = 1'b0;
    w_pick = r_rr_ptr;
    v_idx  = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      v_idx = int'(r_rr_ptr) + k;
      if (v_idx >= N_REQ) begin
        v_idx = v_idx - N_REQ;
      end
      if (bus.req_valid_i[ID_W'(v_idx)]) begin
        w_any  = 1'b1;
        w_pick = ID_W'(v_idx);
      end
    end
  end

  assign w_a_sel   = bus.req_a_i[w_pick*DATA_W +: DATA_W];
  assign w_b_sel   = bus.req_b_i[w_pick*DATA_W +: DATA_W];
  // The core status is only looked at here; a busy core blocks new grants.
  assign w_accept  = (r_state == S_IDLE) && !bus.core_busy_i && w_any && !rst_i;
  assign w_zero_op = (w_a_sel == '0) || (w_b_sel == '0);
  assign w_timeout = (r_timer == TM_W'(TIMEOUT - 1));
  assign w_rsp_hs  = (r_state == S_RESP) && bus.rsp_ready_i[r_grant_id];

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = w_zero_op ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (bus.core_valid_i || w_timeout) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        if (w_rsp_hs) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Job datapath: operands, grant, timer, response and round-robin pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      r_timer    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a        <= w_a_sel;
            r_b        <= w_b_sel;
            r_grant_id <= w_pick;
            if (w_zero_op) begin
              // gcd(0,x) = x and gcd(0,0) = 0, so OR gives the answer directly.
              r_rsp_data <= w_a_sel | w_b_sel;
              r_rsp_err  <= 1'b0;
            end
          end
        end
        S_ISSUE: begin
          r_timer <= '0;
        end
        S_WAIT: begin
          // A result arriving on the last allowed cycle beats the timeout.
          if (bus.core_valid_i) begin
            r_rsp_data <= bus.core_result_i;
            r_rsp_err  <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_RESP: begin
          if (w_rsp_hs) begin
            r_rr_ptr <= (r_grant_id == ID_W'(N_REQ - 1)) ? '0 : r_grant_id + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    bus.req_ready_o = w_accept ? (ONE_HOT0 << w_pick) : '0;
    bus.rsp_valid_o = (r_state == S_RESP) ? (ONE_HOT0 << r_grant_id) : '0;
    bus.rsp_data_o  = r_rsp_data;
    bus.rsp_err_o   = r_rsp_err;
    bus.grant_id_o  = r_grant_id;
    bus.core_req_o  = (r_state == S_ISSUE);
    bus.core_a_o    = '0;
    bus.core_b_o    = '0;
    // Operands are presented only while the core owns the job.
    if ((r_state == S_ISSUE) || (r_state == S_WAIT)) begin
      bus.core_a_o = r_a;
      bus.core_b_o = r_b;
    end
  end

endmodule

// File: tb/tb_gcd_rr_scheduler.sv
// Purpose : directed, table-driven check of the round-robin GCD scheduler with a programmable core model.
// Latency : the core model answers a fixed number of cycles after core_req_o, or never.
// Backpressure: bench drives rsp_ready_i explicitly, including long stalls.
module tb_gcd_rr_scheduler;

  localparam int N_REQ   = 4;
  localparam int DATA_W  = 4;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gcd_rr_scheduler_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

  gcd_rr_scheduler #(.N_REQ(N_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  // Core model: answers core_res_cfg core_lat_cfg cycles after the start
  // pulse (0 = never); unaffected by the scheduler reset.
  logic        core_valid  = 1'b0;
  logic [3:0]  core_result = 4'd0;
  logic        core_active = 1'b0;
  int          core_cnt    = 0;
  int          core_lat_cfg = 1;
  logic [3:0]  core_res_cfg = 4'd0;
  logic        force_busy = 1'b0;

  assign bus.core_valid_i  = core_valid;
  assign bus.core_result_i = core_result;
  assign bus.core_busy_i   = core_active | force_busy;

  always @(posedge clk) begin
    core_valid <= 1'b0;
    if (bus.core_req_o) begin
      core_result <= core_res_cfg;
      if (core_lat_cfg == 1) begin
        core_valid <= 1'b1;
      end else if (core_lat_cfg > 1) begin
        core_active <= 1'b1;
        core_cnt    <= core_lat_cfg - 1;
      end
    end else if (core_active) begin
      if (core_cnt == 1) begin
        core_valid  <= 1'b1;
        core_active <= 1'b0;
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid_i = '0;
    bus.rsp_ready_i = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  // One job from a single requester, starting in IDLE and ending back in IDLE.
  // exp_n = cycles from the cycle after the request handshake until rsp_valid_o rises.
  task automatic run_job(input string nm, input int idx, input logic [3:0] a, input logic [3:0] b,
                         input int lat, input logic [3:0] res, input logic [3:0] exp_d,
                         input logic exp_e, input int exp_n, input int exp_core);
    int n;
    int pulses;
    logic hold_bad;
    core_lat_cfg = lat;
    core_res_cfg = res;
    bus.req_valid_i = '0;
    bus.req_valid_i[idx] = 1'b1;
    bus.req_a_i[idx*DATA_W +: DATA_W] = a;
    bus.req_b_i[idx*DATA_W +: DATA_W] = b;
    #1;
    chk({nm, " req_ready"}, 32'(bus.req_ready_o), 32'(1 << idx));
    tick();
    bus.req_valid_i[idx] = 1'b0;
    chk({nm, " grant_id"}, 32'(bus.grant_id_o), 32'(idx));
    chk({nm, " core_req T+1"}, 32'(bus.core_req_o), 32'(exp_core));
    n = 0;
    pulses = 0;
    hold_bad = 1'b0;
    while (bus.rsp_valid_o == '0 && n < 300) begin
      if (bus.core_req_o) pulses++;
      if (exp_core != 0 && (bus.core_a_o !== a || bus.core_b_o !== b)) hold_bad = 1'b1;
      tick();
      n++;
    end
    chk({nm, " rsp latency"}, 32'(n), 32'(exp_n));
    chk({nm, " core_req pulses"}, 32'(pulses), 32'(exp_core));
    chk({nm, " operand hold"}, 32'(hold_bad), 32'd0);
    chk({nm, " rsp_valid"}, 32'(bus.rsp_valid_o), 32'(1 << idx));
    chk({nm, " rsp_data"}, 32'(bus.rsp_data_o), 32'(exp_d));
    chk({nm, " rsp_err"}, 32'(bus.rsp_err_o), 32'(exp_e));
    bus.rsp_ready_i[idx] = 1'b1;
    tick();
    bus.rsp_ready_i = '0;
    chk({nm, " rsp_valid after hs"}, 32'(bus.rsp_valid_o), 32'd0);
  endtask

  typedef struct {
    string      nm;
    int         idx;
    logic [3:0] a;
    logic [3:0] b;
    int         lat;
    logic [3:0] res;
    logic [3:0] exp_d;
    logic       exp_e;
    int         exp_n;
    int         exp_core;
  } vec_t;

  vec_t tv[9];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    tv[0] = '{"gcd12_8",      0, 4'd12, 4'd8,  5,  4'd4, 4'd4,  1'b0, 6,  1};
    tv[1] = '{"gcd9_6",       1, 4'd9,  4'd6,  1,  4'd3, 4'd3,  1'b0, 2,  1};
    tv[2] = '{"zero_a",       2, 4'd0,  4'd9,  5,  4'd0, 4'd9,  1'b0, 0,  0};
    tv[3] = '{"zero_both",    2, 4'd0,  4'd0,  5,  4'd0, 4'd0,  1'b0, 0,  0};
    tv[4] = '{"zero_b",       3, 4'd15, 4'd0,  5,  4'd0, 4'd15, 1'b0, 0,  0};
    tv[5] = '{"gcd15_10",     3, 4'd15, 4'd10, 3,  4'd5, 4'd5,  1'b0, 4,  1};
    tv[6] = '{"timeout",      1, 4'd7,  4'd5,  0,  4'd1, 4'd0,  1'b1, 65, 1};
    tv[7] = '{"coincide",     0, 4'd8,  4'd4,  64, 4'd4, 4'd4,  1'b0, 65, 1};
    tv[8] = '{"last_wait",    2, 4'd14, 4'd6,  63, 4'd2, 4'd2,  1'b0, 64, 1};

    bus.req_valid_i = '0;
    bus.req_a_i     = '0;
    bus.req_b_i     = '0;
    bus.rsp_ready_i = '0;

    // Reset state
    do_reset();
    chk("reset req_ready", 32'(bus.req_ready_o), 32'd0);
    chk("reset rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("reset rsp_data", 32'(bus.rsp_data_o), 32'd0);
    chk("reset rsp_err", 32'(bus.rsp_err_o), 32'd0);
    chk("reset core_req", 32'(bus.core_req_o), 32'd0);
    chk("reset core_a", 32'(bus.core_a_o), 32'd0);
    chk("reset core_b", 32'(bus.core_b_o), 32'd0);
    chk("reset grant_id", 32'(bus.grant_id_o), 32'd0);

    // Busy core blocks grants in IDLE
    force_busy = 1'b1;
    bus.req_valid_i = 4'b0001;
    bus.req_a_i[3:0] = 4'd12;
    bus.req_b_i[3:0] = 4'd8;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("busy req_ready", 32'(bus.req_ready_o), 32'd0);
      tick();
    end
    force_busy = 1'b0;

    // Table-driven jobs
    for (int i = 0; i < 9; i++) begin
      run_job(tv[i].nm, tv[i].idx, tv[i].a, tv[i].b, tv[i].lat, tv[i].res,
              tv[i].exp_d, tv[i].exp_e, tv[i].exp_n, tv[i].exp_core);
    end

    // All four requesting after reset: granted 0,1,2,3 (zero-operand jobs, data = k+1)
    do_reset();
    for (int k = 0; k < N_REQ; k++) begin
      bus.req_a_i[k*DATA_W +: DATA_W] = 4'd0;
      bus.req_b_i[k*DATA_W +: DATA_W] = 4'(k + 1);
    end
    bus.req_valid_i = 4'b1111;
    for (int k = 0; k < N_REQ; k++) begin
      #1;
      chk($sformatf("rr order ready k=%0d", k), 32'(bus.req_ready_o), 32'(1 << k));
      tick();
      bus.req_valid_i[k] = 1'b0;
      chk($sformatf("rr order rsp_valid k=%0d", k), 32'(bus.rsp_valid_o), 32'(1 << k));
      chk($sformatf("rr order data k=%0d", k), 32'(bus.rsp_data_o), 32'(k + 1));
      bus.rsp_ready_i[k] = 1'b1;
      tick();
      bus.rsp_ready_i = '0;
    end
    // Pointer wrapped to 0: req0 beats req3
    bus.req_valid_i = 4'b1001;
    #1;
    chk("wrap ready first", 32'(bus.req_ready_o), 32'b0001);
    tick();
    bus.req_valid_i[0] = 1'b0;
    bus.rsp_ready_i[0] = 1'b1;
    tick();
    bus.rsp_ready_i = '0;
    #1;
    chk("wrap ready second", 32'(bus.req_ready_o), 32'b1000);
    tick();
    bus.req_valid_i[3] = 1'b0;
    bus.rsp_ready_i[3] = 1'b1;
    tick();
    bus.rsp_ready_i = '0;

    // Response stall: 10 cycles of rsp_ready low for req1, others requesting
    bus.req_a_i[1*DATA_W +: DATA_W] = 4'd0;
    bus.req_b_i[1*DATA_W +: DATA_W] = 4'd5;
    bus.req_a_i[2*DATA_W +: DATA_W] = 4'd0;
    bus.req_b_i[2*DATA_W +: DATA_W] = 4'd3;
    bus.req_a_i[0*DATA_W +: DATA_W] = 4'd0;
    bus.req_b_i[0*DATA_W +: DATA_W] = 4'd1;
    bus.req_valid_i = 4'b0010;
    #1;
    chk("stall ready req1", 32'(bus.req_ready_o), 32'b0010);
    tick();
    bus.req_valid_i = 4'b0101;
    bus.rsp_ready_i = 4'b1001;   // non-granted ready bits must be ignored
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("stall rsp_valid c%0d", i), 32'(bus.rsp_valid_o), 32'b0010);
      chk($sformatf("stall rsp_data c%0d", i), 32'(bus.rsp_data_o), 32'd5);
      chk($sformatf("stall req_ready c%0d", i), 32'(bus.req_ready_o), 32'd0);
      tick();
    end
    bus.rsp_ready_i = 4'b0010;
    tick();
    bus.rsp_ready_i = '0;
    #1;
    chk("after stall ready req2", 32'(bus.req_ready_o), 32'b0100);
    tick();
    bus.req_valid_i[2] = 1'b0;
    chk("after stall data req2", 32'(bus.rsp_data_o), 32'd3);
    bus.rsp_ready_i[2] = 1'b1;
    tick();
    bus.rsp_ready_i = '0;
    #1;
    chk("after stall ready req0", 32'(bus.req_ready_o), 32'b0001);
    tick();
    bus.req_valid_i[0] = 1'b0;
    bus.rsp_ready_i[0] = 1'b1;
    tick();
    bus.rsp_ready_i = '0;

    // Reset in the middle of WAIT; late core result must be ignored
    core_lat_cfg = 10;
    core_res_cfg = 4'd2;
    bus.req_a_i[2*DATA_W +: DATA_W] = 4'd6;
    bus.req_b_i[2*DATA_W +: DATA_W] = 4'd4;
    bus.req_valid_i = 4'b0100;
    tick();
    bus.req_valid_i = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("midwait rst core_req", 32'(bus.core_req_o), 32'd0);
    chk("midwait rst core_a", 32'(bus.core_a_o), 32'd0);
    chk("midwait rst core_b", 32'(bus.core_b_o), 32'd0);
    chk("midwait rst rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("midwait rst rsp_data", 32'(bus.rsp_data_o), 32'd0);
    chk("midwait rst rsp_err", 32'(bus.rsp_err_o), 32'd0);
    chk("midwait rst grant_id", 32'(bus.grant_id_o), 32'd0);
    chk("midwait rst req_ready", 32'(bus.req_ready_o), 32'd0);
    rst = 1'b0;
    begin
      logic stray_rsp;
      stray_rsp = 1'b0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (bus.rsp_valid_o != '0 || bus.core_req_o) stray_rsp = 1'b1;
      end
      chk("late core_valid ignored", 32'(stray_rsp), 32'd0);
    end
    // Pointer back at 0: req0 beats req1
    bus.req_valid_i = 4'b0011;
    #1;
    chk("post-reset rr_ptr", 32'(bus.req_ready_o), 32'b0001);
    run_job("post_reset_job", 0, 4'd6, 4'd9, 2, 4'd3, 4'd3, 1'b0, 3, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
